// File: rtl/dec_char_stream_out.sv
// Drains one slot of the decimal-character result RAM and streams its 47 ASCII chars,
// MSB byte first, on a valid/ready byte interface, retrying reads while the slot is not ready.
module dec_char_stream_out #(
  parameter int unsigned MAX_RETRY     = 32,
  parameter bit          SKIP_LEAD_NUL = 1'b1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         req_valid_i,
  input  logic [3:0]   req_addrs_i,
  output logic         req_ready_o,
  output logic         rden_o,
  output logic [3:0]   rdaddrs_o,
  input  logic [375:0] rddata_i,
  input  logic [1:0]   exceptCode_i,
  input  logic         ready_i,
  output logic         char_valid_o,
  output logic [7:0]   char_data_o,
  output logic         char_last_o,
  input  logic         char_ready_i,
  output logic [1:0]   exceptCode_o,
  output logic         rd_timeout_o,
  output logic         busy_o
);

  localparam logic [5:0] LAST_IDX   = 6'd46;
  localparam logic [7:0] RETRY_LAST = 8'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CHECK,
    SKIP,
    SEND
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     addr_q, addr_d;
  logic [7:0]     retry_q, retry_d;
  logic [5:0]     idx_q, idx_d;
  logic [375:0]   shreg_q, shreg_d;
  logic [1:0]     exc_q, exc_d;
  logic           timeout_q, timeout_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      addr_q    <= 4'd0;
      retry_q   <= 8'd0;
      idx_q     <= 6'd0;
      shreg_q   <= '0;
      exc_q     <= 2'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      retry_q   <= retry_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      exc_q     <= exc_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    retry_d   = retry_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    exc_d     = exc_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addrs_i;
          retry_d = 8'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (ready_i) begin
          shreg_d = rddata_i;
          exc_d   = exceptCode_i;
          idx_d   = 6'd0;
          // Only enter SKIP when there really is a NUL to drop, so a non-NUL first
          // char costs no extra cycle.
          if (SKIP_LEAD_NUL && (rddata_i[375:368] == 8'h00)) begin
            state_d = SKIP;
          end else begin
            state_d = SEND;
          end
        end else if (retry_q == RETRY_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          retry_d = retry_q + 8'd1;
          state_d = ISSUE;
        end
      end
      SKIP: begin
        shreg_d = {shreg_q[367:0], 8'h00};
        idx_d   = idx_q + 6'd1;
        if ((shreg_q[367:360] != 8'h00) || (idx_q == LAST_IDX - 6'd1)) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (char_ready_i) begin
          shreg_d = {shreg_q[367:0], 8'h00};
          if (idx_q == LAST_IDX) begin
            idx_d   = 6'd0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready_o  = 1'b0;
    rden_o       = 1'b0;
    char_valid_o = 1'b0;
    char_last_o  = 1'b0;
    case (state_q)
      IDLE:  req_ready_o = 1'b1;
      ISSUE: rden_o      = 1'b1;
      SEND: begin
        char_valid_o = 1'b1;
        char_last_o  = (idx_q == LAST_IDX);
      end
      default: ;
    endcase
  end

  assign rdaddrs_o    = addr_q;
  assign char_data_o  = shreg_q[375:368];
  assign exceptCode_o = exc_q;
  assign rd_timeout_o = timeout_q;
  assign busy_o       = ~req_ready_o;

endmodule

// File: tb/tb_dec_char_stream_out.sv
// Directed bench for dec_char_stream_out: instance A (MAX_RETRY=4, skip NULs) and
// instance B (no NUL skipping) with hand-computed expected streams and cycle positions.
module tb_dec_char_stream_out;

  logic         clk = 1'b0;
  logic         reset;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  logic         a_req_valid, a_req_ready, a_rden, a_ready_in, a_char_valid, a_char_last;
  logic         a_char_ready, a_rd_timeout, a_busy;
  logic [3:0]   a_req_addrs, a_rdaddrs;
  logic [375:0] a_rddata;
  logic [1:0]   a_exc_in, a_exc_out;
  logic [7:0]   a_char_data;

  logic         b_req_valid, b_req_ready, b_rden, b_ready_in, b_char_valid, b_char_last;
  logic         b_char_ready, b_rd_timeout, b_busy;
  logic [3:0]   b_req_addrs, b_rdaddrs;
  logic [375:0] b_rddata;
  logic [1:0]   b_exc_in, b_exc_out;
  logic [7:0]   b_char_data;

  always #5 clk = ~clk;

  dec_char_stream_out #(.MAX_RETRY(4), .SKIP_LEAD_NUL(1'b1)) dutA (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(a_req_valid), .req_addrs_i(a_req_addrs), .req_ready_o(a_req_ready),
    .rden_o(a_rden), .rdaddrs_o(a_rdaddrs), .rddata_i(a_rddata),
    .exceptCode_i(a_exc_in), .ready_i(a_ready_in),
    .char_valid_o(a_char_valid), .char_data_o(a_char_data), .char_last_o(a_char_last),
    .char_ready_i(a_char_ready), .exceptCode_o(a_exc_out),
    .rd_timeout_o(a_rd_timeout), .busy_o(a_busy)
  );

  dec_char_stream_out #(.MAX_RETRY(32), .SKIP_LEAD_NUL(1'b0)) dutB (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(b_req_valid), .req_addrs_i(b_req_addrs), .req_ready_o(b_req_ready),
    .rden_o(b_rden), .rdaddrs_o(b_rdaddrs), .rddata_i(b_rddata),
    .exceptCode_i(b_exc_in), .ready_i(b_ready_in),
    .char_valid_o(b_char_valid), .char_data_o(b_char_data), .char_last_o(b_char_last),
    .char_ready_i(b_char_ready), .exceptCode_o(b_exc_out),
    .rd_timeout_o(b_rd_timeout), .busy_o(b_busy)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Presents a one-cycle request to A; on return the bench sits in cycle 1.
  task automatic start_req_a(input logic [3:0] addr);
    a_req_valid = 1'b1;
    a_req_addrs = addr;
    tick();
    a_req_valid = 1'b0;
    cyc = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got %b want 1", a_req_ready); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", a_busy); end
    checks++; if (a_rden !== 1'b0) begin errors++; $display("[TB] FAIL reset_rden got %b want 0", a_rden); end
    checks++; if (a_char_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_char_valid got %b want 0", a_char_valid); end
    checks++; if (a_char_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_char_last got %b want 0", a_char_last); end
    checks++; if (a_rd_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_timeout got %b want 0", a_rd_timeout); end
    checks++; if (a_rdaddrs !== 4'd0) begin errors++; $display("[TB] FAIL reset_rdaddrs got %h want 0", a_rdaddrs); end
    checks++; if (a_char_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_char_data got %h want 00", a_char_data); end
    checks++; if (a_exc_out !== 2'b00) begin errors++; $display("[TB] FAIL reset_exc got %b want 00", a_exc_out); end
    checks++; if (b_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_b_req_ready got %b want 1", b_req_ready); end
  endtask

  // T1: 40 leading NULs then "+1.5E+0"; first char appears at cycle 3 + 40.
  task automatic test_skip_nul();
    logic [7:0] expc [7] = '{8'h2B, 8'h31, 8'h2E, 8'h35, 8'h45, 8'h2B, 8'h30};
    a_char_ready = 1'b1;
    start_req_a(4'd3);
    checks++; if (a_rden !== 1'b1 || a_rdaddrs !== 4'd3) begin errors++; $display("[TB] FAIL t1_issue rden=%b addr=%h want 1/3", a_rden, a_rdaddrs); end
    checks++; if (a_busy !== 1'b1) begin errors++; $display("[TB] FAIL t1_busy got %b want 1", a_busy); end
    a_rddata   = {320'h0, 56'h2B312E35452B30};
    a_exc_in   = 2'b11;
    a_ready_in = 1'b1;
    tick();
    checks++; if (a_rden !== 1'b0) begin errors++; $display("[TB] FAIL t1_rden_pulse got %b want 0", a_rden); end
    tick();
    a_ready_in = 1'b0;
    a_rddata   = {47{8'hEE}};
    a_exc_in   = 2'b00;
    for (int i = 0; i < 100; i++) begin
      if (a_char_valid === 1'b1) break;
      tick();
    end
    checks++; if (cyc !== 43) begin errors++; $display("[TB] FAIL t1_first_char_cycle got %0d want 43", cyc); end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (a_char_valid !== 1'b1 || a_char_data !== expc[k] || a_char_last !== (k == 6)) begin
        errors++;
        $display("[TB] FAIL t1_char%0d got v=%b d=%h l=%b want 1/%h/%b", k, a_char_valid, a_char_data, a_char_last, expc[k], (k == 6));
      end
      tick();
    end
    checks++; if (a_req_ready !== 1'b1 || a_char_valid !== 1'b0) begin errors++; $display("[TB] FAIL t1_idle rr=%b cv=%b want 1/0", a_req_ready, a_char_valid); end
    checks++; if (a_exc_out !== 2'b11) begin errors++; $display("[TB] FAIL t1_exc got %b want 11", a_exc_out); end
  endtask

  // T2: three not-ready reads, fourth succeeds; rden at cycles 1,3,5,7, first char at 9.
  task automatic test_retry();
    for (int k = 0; k < 47; k++) a_rddata[375 - 8*k -: 8] = 8'h41 + 8'(k);
    a_exc_in     = 2'b01;
    a_ready_in   = 1'b0;
    a_char_ready = 1'b1;
    start_req_a(4'd5);
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (a_rden !== ((c % 2) == 1) || a_rd_timeout !== 1'b0) begin
        errors++;
        $display("[TB] FAIL t2_rden_c%0d got rden=%b to=%b want %b/0", c, a_rden, a_rd_timeout, ((c % 2) == 1));
      end
      a_ready_in = (c == 8);
      tick();
    end
    a_ready_in = 1'b0;
    checks++; if (a_char_valid !== 1'b1 || a_char_data !== 8'h41) begin errors++; $display("[TB] FAIL t2_first_char c9 got v=%b d=%h want 1/41", a_char_valid, a_char_data); end
    for (int k = 0; k < 47; k++) begin
      checks++;
      if (a_char_valid !== 1'b1 || a_char_data !== 8'h41 + 8'(k) || a_char_last !== (k == 46)) begin
        errors++;
        $display("[TB] FAIL t2_char%0d got v=%b d=%h l=%b want 1/%h/%b", k, a_char_valid, a_char_data, a_char_last, 8'h41 + 8'(k), (k == 46));
      end
      tick();
    end
    checks++; if (a_req_ready !== 1'b1 || a_exc_out !== 2'b01) begin errors++; $display("[TB] FAIL t2_done rr=%b exc=%b want 1/01", a_req_ready, a_exc_out); end
  endtask

  // T3: slot never ready, MAX_RETRY=4 -> four reads, timeout pulse, no chars.
  task automatic test_timeout();
    int pulses = 0;
    a_ready_in = 1'b0;
    a_exc_in   = 2'b10;
    start_req_a(4'd7);
    for (int c = 1; c <= 8; c++) begin
      if (a_rden === 1'b1) pulses++;
      checks++;
      if (a_rd_timeout !== 1'b0 || a_char_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL t3_early_c%0d got to=%b cv=%b want 0/0", c, a_rd_timeout, a_char_valid);
      end
      tick();
    end
    checks++; if (pulses !== 4) begin errors++; $display("[TB] FAIL t3_rden_count got %0d want 4", pulses); end
    checks++; if (a_rd_timeout !== 1'b1 || a_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL t3_timeout got to=%b rr=%b want 1/1", a_rd_timeout, a_req_ready); end
    checks++; if (a_exc_out !== 2'b01) begin errors++; $display("[TB] FAIL t3_exc_held got %b want 01", a_exc_out); end
    tick();
    checks++; if (a_rd_timeout !== 1'b0 || a_rden !== 1'b0 || a_char_valid !== 1'b0) begin errors++; $display("[TB] FAIL t3_after to=%b rden=%b cv=%b want 0/0/0", a_rd_timeout, a_rden, a_char_valid); end
  endtask

  // T4: instance B emits all 47 bytes (including leading NUL) with char_ready toggling.
  task automatic test_backpressure();
    int n = 0;
    logic [7:0] prev;
    logic prevStall = 1'b0;
    for (int k = 0; k < 47; k++) b_rddata[375 - 8*k -: 8] = 8'(k * 3);
    b_exc_in    = 2'b10;
    b_ready_in  = 1'b1;
    b_req_valid = 1'b1;
    b_req_addrs = 4'hC;
    tick();
    b_req_valid = 1'b0;
    cyc = 1;
    tick();
    tick();
    checks++; if (b_char_valid !== 1'b1 || cyc !== 3) begin errors++; $display("[TB] FAIL t4_first_char cv=%b cycle=%0d want 1/3", b_char_valid, cyc); end
    b_char_ready = 1'b1;
    for (int i = 0; i < 200 && n < 47; i++) begin
      checks++;
      if (b_char_valid !== 1'b1 || b_char_data !== 8'(n * 3) || b_char_last !== (n == 46)) begin
        errors++;
        $display("[TB] FAIL t4_byte%0d got v=%b d=%h l=%b want 1/%h/%b", n, b_char_valid, b_char_data, b_char_last, 8'(n * 3), (n == 46));
      end
      if (prevStall) begin
        checks++;
        if (b_char_data !== prev) begin errors++; $display("[TB] FAIL t4_stall_hold got %h want %h", b_char_data, prev); end
      end
      prev      = b_char_data;
      prevStall = ~b_char_ready;
      if (b_char_ready) n++;
      tick();
      b_char_ready = ~b_char_ready;
    end
    checks++; if (n !== 47) begin errors++; $display("[TB] FAIL t4_count got %0d want 47", n); end
    checks++; if (b_req_ready !== 1'b1 || b_char_valid !== 1'b0 || b_exc_out !== 2'b10) begin errors++; $display("[TB] FAIL t4_done rr=%b cv=%b exc=%b want 1/0/10", b_req_ready, b_char_valid, b_exc_out); end
  endtask

  // T5: request while busy is ignored; reset mid-SEND drops the string.
  task automatic test_reset_midsend();
    for (int k = 0; k < 47; k++) a_rddata[375 - 8*k -: 8] = 8'h61 + 8'(k);
    a_exc_in     = 2'b10;
    a_ready_in   = 1'b1;
    a_char_ready = 1'b1;
    start_req_a(4'd2);
    tick();
    tick();
    a_ready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (a_char_valid !== 1'b1 || a_char_data !== 8'h61 + 8'(k)) begin
        errors++;
        $display("[TB] FAIL t5_char%0d got v=%b d=%h want 1/%h", k, a_char_valid, a_char_data, 8'h61 + 8'(k));
      end
      if (k >= 2) begin
        checks++;
        if (a_rden !== 1'b0 || a_rdaddrs !== 4'd2 || a_req_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL t5_busy_ignore got rden=%b addr=%h rr=%b want 0/2/0", a_rden, a_rdaddrs, a_req_ready);
        end
      end
      a_req_valid = (k >= 1);
      a_req_addrs = 4'h9;
      tick();
    end
    a_req_valid = 1'b0;
    reset       = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (a_char_valid !== 1'b0 || a_req_ready !== 1'b1 || a_exc_out !== 2'b00 || a_char_last !== 1'b0) begin errors++; $display("[TB] FAIL t5_after_reset cv=%b rr=%b exc=%b cl=%b want 0/1/00/0", a_char_valid, a_req_ready, a_exc_out, a_char_last); end
    for (int k = 0; k < 47; k++) a_rddata[375 - 8*k -: 8] = 8'h41 + 8'(k);
    a_exc_in   = 2'b01;
    a_ready_in = 1'b1;
    start_req_a(4'd4);
    tick();
    tick();
    a_ready_in = 1'b0;
    for (int k = 0; k < 47; k++) begin
      checks++;
      if (a_char_valid !== 1'b1 || a_char_data !== 8'h41 + 8'(k) || a_char_last !== (k == 46)) begin
        errors++;
        $display("[TB] FAIL t5_new_char%0d got v=%b d=%h l=%b want 1/%h/%b", k, a_char_valid, a_char_data, a_char_last, 8'h41 + 8'(k), (k == 46));
      end
      tick();
    end
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL t5_done rr=%b want 1", a_req_ready); end
  endtask

  // T6: all-NUL string collapses to a single final NUL at cycle 49.
  task automatic test_all_nul();
    a_rddata     = '0;
    a_exc_in     = 2'b00;
    a_ready_in   = 1'b1;
    a_char_ready = 1'b1;
    start_req_a(4'd1);
    tick();
    tick();
    a_ready_in = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (a_char_valid === 1'b1) break;
      tick();
    end
    checks++; if (cyc !== 49) begin errors++; $display("[TB] FAIL t6_cycle got %0d want 49", cyc); end
    checks++; if (a_char_valid !== 1'b1 || a_char_data !== 8'h00 || a_char_last !== 1'b1) begin errors++; $display("[TB] FAIL t6_char got v=%b d=%h l=%b want 1/00/1", a_char_valid, a_char_data, a_char_last); end
    tick();
    checks++; if (a_req_ready !== 1'b1 || a_char_valid !== 1'b0 || a_exc_out !== 2'b00) begin errors++; $display("[TB] FAIL t6_done rr=%b cv=%b exc=%b want 1/0/00", a_req_ready, a_char_valid, a_exc_out); end
  endtask

  initial begin
    reset        = 1'b1;
    a_req_valid  = 1'b0; a_req_addrs = 4'd0; a_rddata = '0; a_exc_in = 2'b00;
    a_ready_in   = 1'b0; a_char_ready = 1'b0;
    b_req_valid  = 1'b0; b_req_addrs = 4'd0; b_rddata = '0; b_exc_in = 2'b00;
    b_ready_in   = 1'b0; b_char_ready = 1'b0;
    test_reset();
    test_skip_nul();
    test_retry();
    test_timeout();
    test_backpressure();
    test_reset_midsend();
    test_all_nul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
